// File: rtl/dll_dlcmsm_mvc.sv
// Multi-VC PCIe Data Link Control and Management State Machine: per-VC InitFC1/InitFC2 tracking and InitFC requests.
// Optional init abort timer enabled by defining DLCM_INIT_TIMEOUT_EN.
module dll_dlcmsm_mvc #(
    parameter int NUM_VC       = 1,
    parameter int TIMER_W      = 16,
    parameter int INIT_TIMEOUT = 50000
) (
    input  logic              sclk,
    input  logic              srst,
    input  logic              pl_link_up_i,
    input  logic [NUM_VC-1:0] vc_en_i,
    input  logic [NUM_VC-1:0] fc1_rx_i,
    input  logic [NUM_VC-1:0] fc2_rx_i,
    input  logic              fc_tx_ready_i,
    output logic              fc_tx_valid_o,
    output logic [2:0]        fc_tx_vc_o,
    output logic              fc_tx_kind_o,
    output logic [1:0]        DLCM_state_o,
    output logic              dl_up_o,
    output logic              dl_down_evt_o,
    output logic              init_timeout_o
);

    if (NUM_VC < 1 || NUM_VC > 8) begin : g_bad_num_vc
        $error("dll_dlcmsm_mvc: NUM_VC must be in 1..8");
    end
    if (INIT_TIMEOUT < 2 || longint'(INIT_TIMEOUT) >= (longint'(1) << TIMER_W)) begin : g_bad_timeout
        $error("dll_dlcmsm_mvc: INIT_TIMEOUT must be >= 2 and fit in TIMER_W bits");
    end

    typedef enum logic [1:0] {
        ST_INACTIVE = 2'd0,
        ST_INIT1    = 2'd1,
        ST_INIT2    = 2'd2,
        ST_ACTIVE   = 2'd3
    } dlcm_state_e;

    dlcm_state_e       state_q, state_d;
    logic [NUM_VC-1:0] vc_mask_q, vc_mask_d;
    logic [NUM_VC-1:0] sent1_q, sent1_d, rx1_q, rx1_d;
    logic [NUM_VC-1:0] sent2_q, sent2_d, rx2_q, rx2_d;
    logic              tx_valid_q, tx_valid_d;
    logic [2:0]        tx_vc_q, tx_vc_d;
    logic              tx_kind_q, tx_kind_d;
    logic              dl_up_q, dl_up_d;
    logic              dl_down_q, dl_down_d;
    logic              timeout_q, timeout_d;

    logic              hs;
    logic [NUM_VC-1:0] hs_vec;
    logic [2:0]        next_vc;
    logic [2:0]        first_vc, after_vc;
    logic              found_after;
    logic              timer_expired;

`ifdef DLCM_INIT_TIMEOUT_EN
    logic [TIMER_W-1:0] timer_q, timer_d;

    // Timer runs through INIT1 and INIT2 and is cleared whenever INACTIVE, i.e. on every INIT1 entry.
    always_comb begin
        timer_d = '0;
        if (state_q == ST_INIT1 || state_q == ST_INIT2) begin
            timer_d = timer_q + 1'b1;
        end
    end

    assign timer_expired = (timer_q >= TIMER_W'(INIT_TIMEOUT - 1));

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) timer_q <= '0;
        else      timer_q <= timer_d;
    end
`else
    assign timer_expired = 1'b0;
`endif

    assign hs = tx_valid_q && fc_tx_ready_i;

    always_comb begin
        hs_vec = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            hs_vec[v] = hs && (tx_vc_q == 3'(v));
        end
    end

    // Round-robin: lowest enabled VC above the current one, else wrap to the lowest enabled VC.
    always_comb begin
        first_vc    = '0;
        after_vc    = '0;
        found_after = 1'b0;
        for (int v = NUM_VC - 1; v >= 0; v--) begin
            if (vc_mask_q[v]) begin
                first_vc = 3'(v);
                if (3'(v) > tx_vc_q) begin
                    after_vc    = 3'(v);
                    found_after = 1'b1;
                end
            end
        end
        next_vc = found_after ? after_vc : first_vc;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        vc_mask_d  = vc_mask_q;
        sent1_d    = sent1_q;
        rx1_d      = rx1_q;
        sent2_d    = sent2_q;
        rx2_d      = rx2_q;
        tx_valid_d = tx_valid_q;
        tx_vc_d    = tx_vc_q;
        dl_down_d  = 1'b0;
        timeout_d  = 1'b0;

        unique case (state_q)
            ST_INACTIVE: begin
                sent1_d    = '0;
                rx1_d      = '0;
                sent2_d    = '0;
                rx2_d      = '0;
                tx_valid_d = 1'b0;
                tx_vc_d    = '0;
                if (pl_link_up_i) begin
                    state_d   = ST_INIT1;
                    vc_mask_d = vc_en_i | NUM_VC'(1);
                end
            end
            ST_INIT1: begin
                sent1_d    = sent1_q | hs_vec;
                rx1_d      = rx1_q | (fc1_rx_i & vc_mask_q);
                rx2_d      = rx2_q | (fc2_rx_i & vc_mask_q);
                tx_valid_d = 1'b1;
                if (hs) tx_vc_d = next_vc;
                if (&(~vc_mask_q | (sent1_d & rx1_d))) begin
                    state_d    = ST_INIT2;
                    tx_valid_d = 1'b0;
                    tx_vc_d    = '0;
                end else if (timer_expired) begin
                    state_d    = ST_INACTIVE;
                    timeout_d  = 1'b1;
                    tx_valid_d = 1'b0;
                    tx_vc_d    = '0;
                end
            end
            ST_INIT2: begin
                sent2_d    = sent2_q | hs_vec;
                rx2_d      = rx2_q | (fc2_rx_i & vc_mask_q);
                tx_valid_d = 1'b1;
                if (hs) tx_vc_d = next_vc;
                if (&(~vc_mask_q | (sent2_d & rx2_d))) begin
                    state_d    = ST_ACTIVE;
                    tx_valid_d = 1'b0;
                    tx_vc_d    = '0;
                end else if (timer_expired) begin
                    state_d    = ST_INACTIVE;
                    timeout_d  = 1'b1;
                    tx_valid_d = 1'b0;
                    tx_vc_d    = '0;
                end
            end
            ST_ACTIVE: begin
                tx_valid_d = 1'b0;
                tx_vc_d    = '0;
            end
            default: state_d = ST_INACTIVE;
        endcase

        // Physical link loss overrides every other event.
        if (!pl_link_up_i) begin
            state_d    = ST_INACTIVE;
            tx_valid_d = 1'b0;
            tx_vc_d    = '0;
            timeout_d  = 1'b0;
            dl_down_d  = (state_q == ST_ACTIVE);
        end

        tx_kind_d = (state_d == ST_INIT2);
        dl_up_d   = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            state_q    <= ST_INACTIVE;
            vc_mask_q  <= NUM_VC'(1);
            sent1_q    <= '0;
            rx1_q      <= '0;
            sent2_q    <= '0;
            rx2_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_vc_q    <= '0;
            tx_kind_q  <= 1'b0;
            dl_up_q    <= 1'b0;
            dl_down_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            vc_mask_q  <= vc_mask_d;
            sent1_q    <= sent1_d;
            rx1_q      <= rx1_d;
            sent2_q    <= sent2_d;
            rx2_q      <= rx2_d;
            tx_valid_q <= tx_valid_d;
            tx_vc_q    <= tx_vc_d;
            tx_kind_q  <= tx_kind_d;
            dl_up_q    <= dl_up_d;
            dl_down_q  <= dl_down_d;
            timeout_q  <= timeout_d;
        end
    end

    assign fc_tx_valid_o  = tx_valid_q;
    assign fc_tx_vc_o     = tx_vc_q;
    assign fc_tx_kind_o   = tx_kind_q;
    assign DLCM_state_o   = state_q;
    assign dl_up_o        = dl_up_q;
    assign dl_down_evt_o  = dl_down_q;
    assign init_timeout_o = timeout_q;

endmodule

// File: tb/tb_dll_dlcmsm_mvc.sv
// Self-checking bench for dll_dlcmsm_mvc: scenario tasks with inline checks plus a request scoreboard.
// The timeout scenario runs when DLCM_INIT_TIMEOUT_EN is defined; otherwise the no-abort behaviour is checked.
module tb_dll_dlcmsm_mvc;

    localparam int NUM_VC = 4;

    typedef struct packed {
        logic [2:0] vc;
        logic       kind;
    } req_t;

    logic              sclk = 1'b0;
    logic              srst;
    logic              pl_link_up;
    logic [NUM_VC-1:0] vc_en;
    logic [NUM_VC-1:0] fc1_rx;
    logic [NUM_VC-1:0] fc2_rx;
    logic              fc_tx_ready;
    logic              fc_tx_valid;
    logic [2:0]        fc_tx_vc;
    logic              fc_tx_kind;
    logic [1:0]        dlcm_state;
    logic              dl_up;
    logic              dl_down_evt;
    logic              init_timeout;

    int   n_checks = 0;
    int   n_pass   = 0;
    req_t exp_q[$];
    logic mon_en   = 1'b0;

    dll_dlcmsm_mvc #(
        .NUM_VC      (NUM_VC),
        .TIMER_W     (16),
        .INIT_TIMEOUT(20)
    ) dut (
        .sclk          (sclk),
        .srst          (srst),
        .pl_link_up_i  (pl_link_up),
        .vc_en_i       (vc_en),
        .fc1_rx_i      (fc1_rx),
        .fc2_rx_i      (fc2_rx),
        .fc_tx_ready_i (fc_tx_ready),
        .fc_tx_valid_o (fc_tx_valid),
        .fc_tx_vc_o    (fc_tx_vc),
        .fc_tx_kind_o  (fc_tx_kind),
        .DLCM_state_o  (dlcm_state),
        .dl_up_o       (dl_up),
        .dl_down_evt_o (dl_down_evt),
        .init_timeout_o(init_timeout)
    );

    always #5 sclk = ~sclk;

    // Every accepted request (valid && ready, sampled mid-cycle) must match the next expected one.
    always @(negedge sclk) begin : req_monitor
        req_t e;
        if (mon_en && fc_tx_valid && fc_tx_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL req_unexpected: got vc=%0d kind=%0d, expected no request", fc_tx_vc, fc_tx_kind);
            end else begin
                e = exp_q.pop_front();
                if (fc_tx_vc !== e.vc || fc_tx_kind !== e.kind)
                    $display("FAIL req_seq: got vc=%0d kind=%0d, expected vc=%0d kind=%0d",
                             fc_tx_vc, fc_tx_kind, e.vc, e.kind);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic req_t mk_req(input int vc, input logic kind);
        req_t r;
        r.vc   = 3'(vc);
        r.kind = kind;
        return r;
    endfunction

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic go_inactive();
        pl_link_up  = 1'b0;
        fc_tx_ready = 1'b0;
        fc1_rx      = '0;
        fc2_rx      = '0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        // NOTE: stimulus uses blocking assignments, applied 1 time unit after the edge so it never races the DUT flops.
        srst        = 1'b1;
        pl_link_up  = 1'b0;
        vc_en       = '0;
        fc1_rx      = '0;
        fc2_rx      = '0;
        fc_tx_ready = 1'b0;
        tick();
        tick();
        if ({dlcm_state, fc_tx_valid, fc_tx_vc, fc_tx_kind, dl_up, dl_down_evt, init_timeout} !== 10'd0)
            $display("FAIL reset_values: got %b, expected all zero",
                     {dlcm_state, fc_tx_valid, fc_tx_vc, fc_tx_kind, dl_up, dl_down_evt, init_timeout});
        else n_pass++;
        n_checks++;
        srst = 1'b0;
        tick();
        if (dlcm_state !== 2'd0) $display("FAIL reset_link_down_idle: state=%0d expected 0", dlcm_state);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_single_vc();
        vc_en       = 4'b0001;
        fc_tx_ready = 1'b1;
        pl_link_up  = 1'b1;
        tick();
        if (dlcm_state !== 2'd1 || fc_tx_valid !== 1'b0)
            $display("FAIL sv_enter_init1: state=%0d valid=%0d expected 1/0", dlcm_state, fc_tx_valid);
        else n_pass++;
        n_checks++;
        tick();
        if ({fc_tx_valid, fc_tx_vc, fc_tx_kind} !== 5'b1_000_0)
            $display("FAIL sv_fc1_req: valid=%0d vc=%0d kind=%0d expected 1/0/0", fc_tx_valid, fc_tx_vc, fc_tx_kind);
        else n_pass++;
        n_checks++;
        tick();
        tick();
        fc1_rx = 4'b0001;
        tick();
        fc1_rx = '0;
        if (dlcm_state !== 2'd2 || fc_tx_valid !== 1'b0)
            $display("FAIL sv_enter_init2: state=%0d valid=%0d expected 2/0", dlcm_state, fc_tx_valid);
        else n_pass++;
        n_checks++;
        tick();
        if ({fc_tx_valid, fc_tx_vc, fc_tx_kind} !== 5'b1_000_1)
            $display("FAIL sv_fc2_req: valid=%0d vc=%0d kind=%0d expected 1/0/1", fc_tx_valid, fc_tx_vc, fc_tx_kind);
        else n_pass++;
        n_checks++;
        tick();
        tick();
        if (dlcm_state !== 2'd2) $display("FAIL sv_wait_fc2: state=%0d expected 2", dlcm_state);
        else n_pass++;
        n_checks++;
        fc2_rx = 4'b0001;
        tick();
        fc2_rx = '0;
        if (dlcm_state !== 2'd3 || dl_up !== 1'b1 || fc_tx_valid !== 1'b0)
            $display("FAIL sv_active: state=%0d dl_up=%0d valid=%0d expected 3/1/0", dlcm_state, dl_up, fc_tx_valid);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_link_down();
        pl_link_up = 1'b0;
        tick();
        if (dlcm_state !== 2'd0 || dl_down_evt !== 1'b1 || dl_up !== 1'b0)
            $display("FAIL ld_drop: state=%0d dl_down=%0d dl_up=%0d expected 0/1/0", dlcm_state, dl_down_evt, dl_up);
        else n_pass++;
        n_checks++;
        pl_link_up = 1'b1;
        tick();
        if (dlcm_state !== 2'd1 || dl_down_evt !== 1'b0)
            $display("FAIL ld_relink: state=%0d dl_down=%0d expected 1/0", dlcm_state, dl_down_evt);
        else n_pass++;
        n_checks++;
        tick();
        if (fc_tx_valid !== 1'b1) $display("FAIL ld_relink_req: valid=%0d expected 1", fc_tx_valid);
        else n_pass++;
        n_checks++;
        pl_link_up = 1'b0;
        tick();
        if (dlcm_state !== 2'd0 || dl_down_evt !== 1'b0 || fc_tx_valid !== 1'b0)
            $display("FAIL ld_drop_from_init: state=%0d dl_down=%0d valid=%0d expected 0/0/0",
                     dlcm_state, dl_down_evt, fc_tx_valid);
        else n_pass++;
        n_checks++;
        tick();
    endtask

    task automatic test_round_robin_stall();
        int errs;
        vc_en       = 4'b0100;
        fc_tx_ready = 1'b0;
        pl_link_up  = 1'b1;
        tick();
        tick();
        if ({fc_tx_valid, fc_tx_vc, fc_tx_kind} !== 5'b1_000_0)
            $display("FAIL rr_first_req: valid=%0d vc=%0d kind=%0d expected 1/0/0", fc_tx_valid, fc_tx_vc, fc_tx_kind);
        else n_pass++;
        n_checks++;
        errs = 0;
        repeat (6) begin
            tick();
            if ({fc_tx_valid, fc_tx_vc, fc_tx_kind} !== 5'b1_000_0) errs++;
        end
        if (errs !== 0) $display("FAIL rr_stall_stable: %0d unstable cycles, expected 0", errs);
        else n_pass++;
        n_checks++;

        mon_en = 1'b1;
        exp_q.push_back(mk_req(0, 1'b0));
        exp_q.push_back(mk_req(2, 1'b0));
        exp_q.push_back(mk_req(0, 1'b0));
        exp_q.push_back(mk_req(2, 1'b0));
        exp_q.push_back(mk_req(0, 1'b0));
        fc_tx_ready = 1'b1;
        repeat (5) tick();
        fc_tx_ready = 1'b0;
        if (exp_q.size() !== 0) $display("FAIL rr_fc1_drained: %0d requests missing, expected 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (fc_tx_vc !== 3'd2) $display("FAIL rr_ptr_after: vc=%0d expected 2", fc_tx_vc);
        else n_pass++;
        n_checks++;

        fc1_rx = 4'b1010;
        tick();
        fc1_rx = 4'b0001;
        tick();
        if (dlcm_state !== 2'd1) $display("FAIL rr_need_vc2: state=%0d expected 1", dlcm_state);
        else n_pass++;
        n_checks++;
        fc1_rx = 4'b0100;
        tick();
        fc1_rx = '0;
        if (dlcm_state !== 2'd2) $display("FAIL rr_enter_init2: state=%0d expected 2", dlcm_state);
        else n_pass++;
        n_checks++;
        exp_q.push_back(mk_req(0, 1'b1));
        exp_q.push_back(mk_req(2, 1'b1));
        tick();
        if ({fc_tx_valid, fc_tx_vc, fc_tx_kind} !== 5'b1_000_1)
            $display("FAIL rr_init2_req: valid=%0d vc=%0d kind=%0d expected 1/0/1", fc_tx_valid, fc_tx_vc, fc_tx_kind);
        else n_pass++;
        n_checks++;
        fc_tx_ready = 1'b1;
        repeat (2) tick();
        fc_tx_ready = 1'b0;
        if (exp_q.size() !== 0) $display("FAIL rr_fc2_drained: %0d requests missing, expected 0", exp_q.size());
        else n_pass++;
        n_checks++;
        fc2_rx = 4'b1010;
        tick();
        if (dlcm_state !== 2'd2) $display("FAIL rr_disabled_fc2: state=%0d expected 2", dlcm_state);
        else n_pass++;
        n_checks++;
        fc2_rx = 4'b0101;
        tick();
        fc2_rx = '0;
        if (dlcm_state !== 2'd3 || dl_up !== 1'b1)
            $display("FAIL rr_active: state=%0d dl_up=%0d expected 3/1", dlcm_state, dl_up);
        else n_pass++;
        n_checks++;
        mon_en = 1'b0;
    endtask

    task automatic test_early_fc2();
        go_inactive();
        vc_en       = 4'b0001;
        pl_link_up  = 1'b1;
        tick();
        fc2_rx = 4'b0001;
        tick();
        fc2_rx = '0;
        if (dlcm_state !== 2'd1) $display("FAIL ef_init1: state=%0d expected 1", dlcm_state);
        else n_pass++;
        n_checks++;
        fc_tx_ready = 1'b1;
        fc1_rx      = 4'b0001;
        tick();
        fc1_rx      = '0;
        fc_tx_ready = 1'b0;
        if (dlcm_state !== 2'd2) $display("FAIL ef_init2: state=%0d expected 2", dlcm_state);
        else n_pass++;
        n_checks++;
        tick();
        tick();
        if (dlcm_state !== 2'd2 || fc_tx_valid !== 1'b1 || fc_tx_kind !== 1'b1)
            $display("FAIL ef_wait_sent2: state=%0d valid=%0d kind=%0d expected 2/1/1",
                     dlcm_state, fc_tx_valid, fc_tx_kind);
        else n_pass++;
        n_checks++;
        fc_tx_ready = 1'b1;
        tick();
        fc_tx_ready = 1'b0;
        if (dlcm_state !== 2'd3) $display("FAIL ef_active: state=%0d expected 3", dlcm_state);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_mid_reset();
        go_inactive();
        vc_en       = 4'b0001;
        fc_tx_ready = 1'b0;
        pl_link_up  = 1'b1;
        tick();
        tick();
        #2;
        srst = 1'b1;
        #1;
        if (dlcm_state !== 2'd0 || fc_tx_valid !== 1'b0)
            $display("FAIL mr_async: state=%0d valid=%0d expected 0/0", dlcm_state, fc_tx_valid);
        else n_pass++;
        n_checks++;
        srst = 1'b0;
        tick();
        if (dlcm_state !== 2'd1) $display("FAIL mr_recover: state=%0d expected 1", dlcm_state);
        else n_pass++;
        n_checks++;
    endtask

`ifdef DLCM_INIT_TIMEOUT_EN
    task automatic test_timeout();
        int errs;
        go_inactive();
        vc_en       = 4'b0001;
        fc_tx_ready = 1'b1;
        pl_link_up  = 1'b1;
        tick();
        errs = 0;
        repeat (19) begin
            tick();
            if (init_timeout !== 1'b0 || dlcm_state === 2'd0) errs++;
        end
        if (errs !== 0) $display("FAIL to_early: %0d premature abort cycles, expected 0", errs);
        else n_pass++;
        n_checks++;
        tick();
        if (init_timeout !== 1'b1 || dlcm_state !== 2'd0)
            $display("FAIL to_abort: timeout=%0d state=%0d expected 1/0", init_timeout, dlcm_state);
        else n_pass++;
        n_checks++;
        tick();
        if (init_timeout !== 1'b0 || dlcm_state !== 2'd1)
            $display("FAIL to_reenter: timeout=%0d state=%0d expected 0/1", init_timeout, dlcm_state);
        else n_pass++;
        n_checks++;
        for (int i = 1; i <= 20; i++) begin
            fc1_rx = (i == 3)  ? 4'b0001 : 4'b0000;
            fc2_rx = (i == 20) ? 4'b0001 : 4'b0000;
            tick();
        end
        fc1_rx = '0;
        fc2_rx = '0;
        if (dlcm_state !== 2'd3 || init_timeout !== 1'b0)
            $display("FAIL to_complete_wins: state=%0d timeout=%0d expected 3/0", dlcm_state, init_timeout);
        else n_pass++;
        n_checks++;
    endtask
`else
    task automatic test_no_timeout();
        int errs;
        go_inactive();
        vc_en       = 4'b0001;
        fc_tx_ready = 1'b1;
        pl_link_up  = 1'b1;
        tick();
        errs = 0;
        repeat (60) begin
            tick();
            if (init_timeout !== 1'b0 || dlcm_state !== 2'd1) errs++;
        end
        if (errs !== 0) $display("FAIL nt_wait_forever: %0d bad cycles, expected 0", errs);
        else n_pass++;
        n_checks++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_vc();
        test_link_down();
        test_round_robin_stall();
        test_early_fc2();
        test_mid_reset();
`ifdef DLCM_INIT_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        go_inactive();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
